// File: rtl/ccff_loader_pkg.sv
// Shared definitions for the configuration-chain bitstream loader:
// the controller state encoding, default parameter values and the
// constant functions that size the counters from CHAIN_LEN and WORD_W.
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_SETTLE,
        ST_DONE
    } state_t;

    localparam int DEF_WORD_W     = 32;
    localparam int DEF_CHAIN_LEN  = 1024;
    localparam int DEF_SETTLE_CYC = 4;

    // Host words needed to cover the whole chain.
    function automatic int words_needed(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // Bits of the final word that actually enter the chain.
    function automatic int last_bits(input int chain_len, input int word_w);
        int rem;
        rem = chain_len % word_w;
        return (rem == 0) ? word_w : rem;
    endfunction

    // Width of a counter that must hold the value n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Width of a bit index into a word_w-bit word.
    function automatic int idx_width(input int word_w);
        return (word_w < 2) ? 1 : $clog2(word_w);
    endfunction

endpackage

// File: rtl/ccff_serdes_word.sv
// One-word serializer/deserializer pair. The load side presents bit
// i_rd_idx of the latched host word; the capture side writes the bit
// leaving the chain into the readback word at i_cap_idx. o_rb_word is the
// readback word including the bit being captured this cycle, so the
// controller can publish a complete word on the same edge that captures
// its last bit. The readback register clears itself after that last bit,
// which leaves uncaptured high bits of a short final word at 0.
module ccff_serdes_word #(
    parameter int WORD_W = 32,
    parameter int WIDX_W = 5
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_load_data,
    input  logic [WIDX_W-1:0] i_rd_idx,
    output logic              o_head_bit,
    input  logic              i_cap_en,
    input  logic [WIDX_W-1:0] i_cap_idx,
    input  logic              i_cap_bit,
    input  logic              i_cap_last,
    output logic [WORD_W-1:0] o_rb_word
);

    logic [WORD_W-1:0] r_shreg;
    logic [WORD_W-1:0] r_rb_shreg;
    logic [WORD_W-1:0] w_rb_merge;

    // Latch the accepted host word for serialization.
    // NOTE: pure datapath register, always written before it is read, so it
    // carries no reset; only state whose reset value is observable is reset.
    always_ff @(posedge prog_clk) begin
        if (i_load) begin
            r_shreg <= i_load_data;
        end
    end

    assign o_head_bit = r_shreg[i_rd_idx];

    // Merge the bit currently leaving the chain into the readback word.
    // NOTE: default assignment first so no path through the block leaves
    // w_rb_merge unassigned (which would infer a latch).
    always_comb begin
        w_rb_merge = r_rb_shreg;
        if (i_cap_en) begin
            w_rb_merge[i_cap_idx] = i_cap_bit;
        end
    end

    assign o_rb_word = w_rb_merge;

    // Accumulate captured bits; start a fresh word after the last one.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_rb_shreg <= '0;
        end else if (i_cap_en) begin
            r_rb_shreg <= i_cap_last ? '0 : w_rb_merge;
        end
    end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Bitstream loader for the IO tile configuration chain. Accepts host
// words on a valid/ready stream, shifts them LSB-first into ccff_head
// with one shift_en pulse per bit, and returns the previous chain
// contents from ccff_tail as readback words. config_enable and IO_ISOL_N
// bracket the whole load; config_enable is held for SETTLE_CYC cycles
// after the last physical shift before done.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int CHAIN_LEN  = DEF_CHAIN_LEN,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic              config_enable,
    output logic              IO_ISOL_N,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              busy,
    output logic              done
);

    localparam int WORDS_NEEDED = words_needed(CHAIN_LEN, WORD_W);
    localparam int LAST_BITS    = last_bits(CHAIN_LEN, WORD_W);
    localparam int CNT_W        = cnt_width(CHAIN_LEN);
    localparam int WIDX_W       = idx_width(WORD_W);
    localparam int WCNT_W       = cnt_width(WORDS_NEEDED);
    localparam int SET_W        = cnt_width(SETTLE_CYC);

    state_t              r_state;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [WIDX_W-1:0]   r_bit_idx;
    logic [WCNT_W-1:0]   r_word_cnt;
    logic [SET_W-1:0]    r_settle_cnt;
    logic [WIDX_W-1:0]   r_cap_idx;
    logic                r_cap_last;

    logic                r_s_ready;
    logic                r_ccff_head;
    logic                r_shift_en;
    logic                r_config_enable;
    logic                r_io_isol_n;
    logic [WORD_W-1:0]   r_rb_data;
    logic                r_rb_valid;
    logic                r_busy;
    logic                r_done;

    logic                w_handshake;
    logic                w_load;
    logic                w_last_word;
    logic [WIDX_W-1:0]   w_word_top;
    logic                w_word_end;
    logic                w_chain_end;
    logic                w_settle_last;
    logic                w_head_bit;
    logic [WORD_W-1:0]   w_rb_word;

    assign w_handshake   = s_valid & r_s_ready;
    assign w_load        = (r_state == ST_FETCH) && w_handshake;
    // r_word_cnt already counts the word being shifted.
    assign w_last_word   = (r_word_cnt == WCNT_W'(WORDS_NEEDED));
    assign w_word_top    = w_last_word ? WIDX_W'(LAST_BITS - 1) : WIDX_W'(WORD_W - 1);
    assign w_word_end    = (r_bit_idx == w_word_top);
    assign w_chain_end   = (r_bit_cnt == CNT_W'(CHAIN_LEN - 1));
    assign w_settle_last = (SETTLE_CYC == 0) || (r_settle_cnt == SET_W'(SETTLE_CYC - 1));

    ccff_serdes_word #(
        .WORD_W (WORD_W),
        .WIDX_W (WIDX_W)
    ) u_serdes (
        .prog_clk    (prog_clk),
        .pReset      (pReset),
        .i_load      (w_load),
        .i_load_data (s_data),
        .i_rd_idx    (r_bit_idx),
        .o_head_bit  (w_head_bit),
        .i_cap_en    (r_shift_en),
        .i_cap_idx   (r_cap_idx),
        .i_cap_bit   (ccff_tail),
        .i_cap_last  (r_cap_last),
        .o_rb_word   (w_rb_word)
    );

    // Load controller: state, counters and all registered chain/host controls.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state         <= ST_IDLE;
            r_bit_cnt       <= '0;
            r_bit_idx       <= '0;
            r_word_cnt      <= '0;
            r_settle_cnt    <= '0;
            r_cap_idx       <= '0;
            r_cap_last      <= 1'b0;
            r_s_ready       <= 1'b0;
            r_ccff_head     <= 1'b0;
            r_shift_en      <= 1'b0;
            r_config_enable <= 1'b0;
            r_io_isol_n     <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_shift_en  <= 1'b0;
                    r_ccff_head <= 1'b0;
                    if (start) begin
                        r_state         <= ST_FETCH;
                        r_busy          <= 1'b1;
                        r_config_enable <= 1'b1;
                        r_io_isol_n     <= 1'b0;
                        r_s_ready       <= 1'b1;
                        r_bit_cnt       <= '0;
                        r_word_cnt      <= '0;
                    end else begin
                        r_io_isol_n <= 1'b1;
                    end
                end

                ST_FETCH: begin
                    r_shift_en  <= 1'b0;
                    r_ccff_head <= 1'b0;
                    if (w_handshake) begin
                        r_state    <= ST_SHIFT;
                        r_s_ready  <= 1'b0;
                        r_bit_idx  <= '0;
                        r_word_cnt <= r_word_cnt + 1'b1;
                    end
                end

                ST_SHIFT: begin
                    // Bit leaves on shift_en next cycle; its tail capture
                    // uses the same index one cycle later.
                    r_shift_en  <= 1'b1;
                    r_ccff_head <= w_head_bit;
                    r_cap_idx   <= r_bit_idx;
                    r_cap_last  <= w_word_end | w_chain_end;
                    r_bit_idx   <= r_bit_idx + 1'b1;
                    if (w_chain_end) begin
                        r_state      <= ST_SETTLE;
                        r_settle_cnt <= '0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (w_word_end) begin
                            r_state   <= ST_FETCH;
                            r_s_ready <= 1'b1;
                        end
                    end
                end

                ST_SETTLE: begin
                    r_shift_en  <= 1'b0;
                    r_ccff_head <= 1'b0;
                    // Settling time counts from the first cycle with no shift.
                    if (!r_shift_en) begin
                        if (w_settle_last) begin
                            r_state         <= ST_DONE;
                            r_config_enable <= 1'b0;
                            r_busy          <= 1'b0;
                            r_done          <= 1'b1;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_done      <= 1'b0;
                    r_io_isol_n <= 1'b1;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Publish a readback word on the edge that captures its last bit.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_rb_data  <= '0;
            r_rb_valid <= 1'b0;
        end else begin
            r_rb_valid <= 1'b0;
            if (r_shift_en && r_cap_last) begin
                r_rb_data  <= w_rb_word;
                r_rb_valid <= 1'b1;
            end
        end
    end

    assign s_ready       = r_s_ready;
    assign ccff_head     = r_ccff_head;
    assign shift_en      = r_shift_en;
    assign config_enable = r_config_enable;
    assign IO_ISOL_N     = r_io_isol_n;
    assign rb_data       = r_rb_data;
    assign rb_valid      = r_rb_valid;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
Upstream feeder for the configuration-chain head of the IO logical tiles: accepts bitstream words from the SoC host on a valid/ready stream and serializes them onto ccff_head. Drives config_enable, the per-bit shift enable to the prog_clk gate, and IO_ISOL_N for the duration of programming. Captures the bits leaving ccff_tail, which are the previous chain contents, into readback words.

Parameters:
WORD_W, 32, host word width in bits (power of two, at least 8).
CHAIN_LEN, 1024, total configuration-chain length in bits (at least 1).
SETTLE_CYC, 4, prog_clk cycles that config_enable stays high after the last shift.

Ports:
prog_clk  in  1  programming clock; all state on rising edge.
pReset  in  1  reset; synchronous, active-high.
start  in  1  one-cycle pulse; begins a load; ignored unless idle.
s_data  in  WORD_W  bitstream word; bit 0 is shifted first.
s_valid  in  1  s_data valid.
s_ready  out  1  word accepted when s_valid and s_ready are both high.
ccff_head  out  1  serial bit into the chain head.
ccff_tail  in  1  serial bit out of the chain tail.
shift_en  out  1  clock-enable to the chain's prog_clk gate; one chain shift per cycle when high.
config_enable  out  1  chain configuration enable.
IO_ISOL_N  out  1  IO isolation, active-low; low means isolated.
rb_data  out  WORD_W  readback word.
rb_valid  out  1  one-cycle pulse; rb_data valid; no backpressure.
busy  out  1  high from the start acceptance to DONE.
done  out  1  one-cycle pulse at completion.

Behaviour:
- Reset values: s_ready=0, ccff_head=0, shift_en=0, config_enable=0, IO_ISOL_N=0, rb_data=0, rb_valid=0, busy=0, done=0. Bit and word counters are cleared.
- States: IDLE, FETCH, SHIFT, SETTLE, DONE.
- IDLE: IO_ISOL_N=1. A start pulse moves to FETCH in the next cycle: busy=1, config_enable=1, IO_ISOL_N=0.
- FETCH: s_ready=1.
  - On a handshake, load the word into the shift register, load bit index 0, go to SHIFT.
  - If s_valid is low, remain in FETCH with shift_en=0. The chain stalls with no shift and no error.
- SHIFT, each cycle:
  - shift_en=1 and ccff_head=shreg[bit index].
  - Capture ccff_tail into rb_shreg[bit index].
  - Increment bit_cnt, which counts 0 to CHAIN_LEN-1.
- End of word in SHIFT:
  - After bit index WORD_W-1, or after the final chain bit, pulse rb_valid the next cycle with the captured word. Uncaptured high bits of the final word read 0.
  - If bits remain, go to FETCH. The fetch cycle costs one bubble, with shift_en=0.
- Final word: words needed = ceil(CHAIN_LEN/WORD_W). Only the low (CHAIN_LEN mod WORD_W) bits of the final word are shifted, or all of them when the remainder is 0. Its unused high bits are discarded.
- SETTLE: shift_en=0, ccff_head=0, config_enable=1. Count SETTLE_CYC cycles, then go to DONE.
- DONE, for one cycle: config_enable=0, done=1, busy=0. IO_ISOL_N returns to 1 in the following cycle, entering IDLE.
- shift_en and ccff_head are registered, so bit k reaches the chain in the cycle after its SHIFT decision. ccff_tail is sampled in the same cycle shift_en is high.
- start while busy: ignored.
- pReset mid-load: all outputs return to reset values in the next cycle. The chain contents are left partial; software must reload.
- Simultaneous start and pReset: reset wins.
- bit_cnt width is clog2(CHAIN_LEN+1). There is no wrap: the transition to SETTLE occurs exactly when bit_cnt==CHAIN_LEN-1 and a shift is issued.

Decomposition:
- Shared package ccff_loader_pkg holds:
  - the state enum (IDLE, FETCH, SHIFT, SETTLE, DONE);
  - localparams WORDS_NEEDED, LAST_BITS, CNT_W and WIDX_W, derived as functions of CHAIN_LEN and WORD_W.
- One natural sub-module, ccff_serdes_word: a WORD_W-bit parallel-load serializer paired with a serial-capture deserializer, indexed by a shared bit pointer. The FSM and counters stay in the top level.

Test Plan:
- CHAIN_LEN=64, WORD_W=32, s_valid always high, words 0xA5A5_0001 then 0x0000_FFFF:
  - 64 shift_en cycles separated by exactly one bubble;
  - ccff_head sequence is 1,0,0,... (LSB first);
  - done pulses SETTLE_CYC+1 cycles after the last shift;
  - IO_ISOL_N is low throughout busy.
- CHAIN_LEN=40, chain model is a 40-bit shift register preloaded with 0x12_3456_789A:
  - exactly 40 shifts;
  - rb_data is 0x3456789A, then 0x00000012;
  - the final 8-bit word consumes a full s_data handshake, with upper 24 bits ignored.
- Host stalls: s_valid low for 10 cycles between words. Required: shift_en=0 and s_ready=1 during the stall, no rb_valid, and the loaded chain is identical to the no-stall case.
- start pulsed again mid-load: no restart, and the bit count totals exactly CHAIN_LEN. Then pReset asserted in SHIFT: next cycle config_enable=0, IO_ISOL_N=0, busy=0, and no done pulse.
- Back-to-back: a second start is accepted the cycle after IO_ISOL_N returns to 1. The chain then holds the second bitstream, and readback returns the first.
